// File: rtl/seg_pkg.sv
// Shared segment codes, FSM state and digit-index types for the stopwatch display.
package seg_pkg;

   localparam logic [7:0] SEG_0     = 8'hFC;
   localparam logic [7:0] SEG_1     = 8'h60;
   localparam logic [7:0] SEG_2     = 8'hDA;
   localparam logic [7:0] SEG_3     = 8'hF2;
   localparam logic [7:0] SEG_4     = 8'h66;
   localparam logic [7:0] SEG_5     = 8'hB6;
   localparam logic [7:0] SEG_6     = 8'hBE;
   localparam logic [7:0] SEG_7     = 8'hE0;
   localparam logic [7:0] SEG_8     = 8'hFE;
   localparam logic [7:0] SEG_9     = 8'hE6;
   localparam logic [7:0] SEG_BLANK = 8'h00;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } state_t;

   typedef logic [1:0] dig_idx_t;

   localparam dig_idx_t DIG_ONES  = 2'd0;
   localparam dig_idx_t DIG_TENS  = 2'd1;
   localparam dig_idx_t DIG_HUNDS = 2'd2;

endpackage

// File: rtl/seg_encode.sv
// BCD digit to active-high segment pattern {a..g, dp}; non-decimal codes blank the digit.
module seg_encode
   import seg_pkg::*;
(
   input  logic [3:0] digit,
   output logic [7:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (digit)
         4'd0: seg = SEG_0;
         4'd1: seg = SEG_1;
         4'd2: seg = SEG_2;
         4'd3: seg = SEG_3;
         4'd4: seg = SEG_4;
         4'd5: seg = SEG_5;
         4'd6: seg = SEG_6;
         4'd7: seg = SEG_7;
         4'd8: seg = SEG_8;
         4'd9: seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/stopwatch_seg_ctrl.sv
// Run/pause/clear 000-999 BCD stopwatch with a multiplexed three-digit segment scanner.
// Optional leading-zero blanking: define SEG_LEADING_BLANK_EN.
module stopwatch_seg_ctrl
   import seg_pkg::*;
#(
   parameter int unsigned TICK_DIV = 1000,
   parameter int unsigned SCAN_DIV = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_start,
   input  logic        btn_stop,
   input  logic        btn_clear,
   output logic [7:0]  seg_out,
   output logic [2:0]  dig_sel,
   output logic [11:0] bcd,
   output logic        running,
   output logic        wrap
);

   localparam int unsigned TW = $clog2(TICK_DIV);
   localparam int unsigned SW = $clog2(SCAN_DIV + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);

   state_t        state;
   logic [TW-1:0] tick_cnt;
   logic [3:0]    d_o, d_t, d_h;
   logic [3:0]    nxt_o, nxt_t, nxt_h;
   logic          carry_o, carry_t, roll;

   always_comb begin
      carry_o = (d_o == 4'd9);
      carry_t = carry_o && (d_t == 4'd9);
      roll    = carry_t && (d_h == 4'd9);
      nxt_o   = carry_o ? 4'd0 : d_o + 4'd1;
      nxt_t   = d_t;
      if (carry_o)
         nxt_t = (d_t == 4'd9) ? 4'd0 : d_t + 4'd1;
      nxt_h   = d_h;
      if (carry_t)
         nxt_h = (d_h == 4'd9) ? 4'd0 : d_h + 4'd1;
   end

   // The prescaler also advances on the edge that samples stop, so a resume
   // continues exactly where the RUN interval left off.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         running  <= 1'b0;
         wrap     <= 1'b0;
         tick_cnt <= '0;
         d_o      <= '0;
         d_t      <= '0;
         d_h      <= '0;
      end else if (btn_clear) begin
         state    <= IDLE;
         running  <= 1'b0;
         wrap     <= 1'b0;
         tick_cnt <= '0;
         d_o      <= '0;
         d_t      <= '0;
         d_h      <= '0;
      end else begin
         wrap <= 1'b0;
         case (state)
            IDLE, PAUSE: begin
               if (btn_start && !btn_stop) begin
                  state   <= RUN;
                  running <= 1'b1;
               end
            end
            RUN: begin
               if (tick_cnt == TICK_LAST) begin
                  tick_cnt <= '0;
                  d_o      <= nxt_o;
                  d_t      <= nxt_t;
                  d_h      <= nxt_h;
                  wrap     <= roll;
               end else begin
                  tick_cnt <= tick_cnt + 1'b1;
               end
               if (btn_stop) begin
                  state   <= PAUSE;
                  running <= 1'b0;
               end
            end
            default: begin
               state   <= IDLE;
               running <= 1'b0;
            end
         endcase
      end
   end

   assign bcd = {d_h, d_t, d_o};

   logic [SW-1:0] scan_cnt;
   dig_idx_t      idx, idx_nxt;
   logic          blank_h, blank_t;
   logic [3:0]    enc_in;
   logic [7:0]    enc_seg;

   always_comb begin
`ifdef SEG_LEADING_BLANK_EN
      blank_h = (d_h == 4'd0);
      blank_t = (d_h == 4'd0) && (d_t == 4'd0);
`else
      blank_h = 1'b0;
      blank_t = 1'b0;
`endif
   end

   // Pattern is chosen from the index being loaded, so select and segments
   // always update together; blanking feeds a non-decimal code to the encoder.
   always_comb begin
      idx_nxt = idx;
      if (scan_cnt == SCAN_LAST)
         idx_nxt = (idx == DIG_HUNDS) ? DIG_ONES : idx + 2'd1;
      case (idx_nxt)
         DIG_TENS:  enc_in = blank_t ? 4'hF : d_t;
         DIG_HUNDS: enc_in = blank_h ? 4'hF : d_h;
         default:   enc_in = d_o;
      endcase
   end

   seg_encode u_enc (
      .digit (enc_in),
      .seg   (enc_seg)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         scan_cnt <= '0;
         idx      <= DIG_ONES;
         dig_sel  <= 3'b001;
         seg_out  <= SEG_0;
      end else begin
         scan_cnt <= (scan_cnt == SCAN_LAST) ? '0 : scan_cnt + 1'b1;
         idx      <= idx_nxt;
         dig_sel  <= 3'(3'b001 << idx_nxt);
         seg_out  <= enc_seg;
      end
   end

endmodule

// File: tb/tb_stopwatch_seg_ctrl.sv
// Directed scoreboard bench for stopwatch_seg_ctrl with TICK_DIV=4, SCAN_DIV=2.
module tb_stopwatch_seg_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        btn_start, btn_stop, btn_clear;
   logic [7:0]  seg_out;
   logic [2:0]  dig_sel;
   logic [11:0] bcd;
   logic        running, wrap;

   int unsigned tests = 0;
   int unsigned fails = 0;

`ifdef SEG_LEADING_BLANK_EN
   localparam logic [7:0] LEAD_ZERO = 8'h00;
`else
   localparam logic [7:0] LEAD_ZERO = 8'hFC;
`endif

   stopwatch_seg_ctrl #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .btn_start (btn_start),
      .btn_stop  (btn_stop),
      .btn_clear (btn_clear),
      .seg_out   (seg_out),
      .dig_sel   (dig_sel),
      .bcd       (bcd),
      .running   (running),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [11:0] exp;
   } exp_t;

   exp_t sb[$];

   task automatic expect_v(input string tag, input logic [11:0] v);
      exp_t e;
      e.tag = tag;
      e.exp = v;
      sb.push_back(e);
   endtask

   task automatic check_v(input logic [11:0] obs);
      exp_t e;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard_empty: got %h expected none", obs);
      end else begin
         e = sb.pop_front();
         tests++;
         assert (obs === e.exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic s, input logic p, input logic c);
      btn_start = s;
      btn_stop  = p;
      btn_clear = c;
      step();
      btn_start = 1'b0;
      btn_stop  = 1'b0;
      btn_clear = 1'b0;
   endtask

   function automatic logic [11:0] to_bcd(input int unsigned v);
      return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   logic [2:0] scan_tab [10];
   logic [2:0] seen;

   initial begin
      scan_tab = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100,
                   3'b100, 3'b001, 3'b001, 3'b010, 3'b010};
      rst = 1'b0;
      btn_start = 1'b0;
      btn_stop  = 1'b0;
      btn_clear = 1'b0;
      #12;
      expect_v("rst_seg", 12'h0FC);   check_v(12'(seg_out));
      expect_v("rst_dig", 12'h001);   check_v(12'(dig_sel));
      expect_v("rst_bcd", 12'h000);   check_v(bcd);
      expect_v("rst_run", 12'h000);   check_v(12'(running));
      expect_v("rst_wrap", 12'h000);  check_v(12'(wrap));
      rst = 1'b1;

      // idle scan rotation
      for (int k = 0; k < 10; k++) begin
         if (k != 0) step();
         expect_v("idle_dig", 12'(scan_tab[k]));
         expect_v("idle_seg", 12'((scan_tab[k] == 3'b001) ? 8'hFC : LEAD_ZERO));
         expect_v("idle_bcd", 12'h000);
         expect_v("idle_run", 12'h000);
         check_v(12'(dig_sel));
         check_v(12'(seg_out));
         check_v(bcd);
         check_v(12'(running));
      end

      // start at edge 0, increments at edges 4 and 8
      expect_v("start_run", 12'h001);
      press(1'b1, 1'b0, 1'b0);
      check_v(12'(running));
      for (int e = 1; e <= 8; e++) begin
         expect_v("first_incs", (e < 4) ? 12'h000 : (e < 8) ? 12'h001 : 12'h002);
         step();
         check_v(bcd);
      end

      // stop two cycles after the increment, pause 20 cycles, resume
      step();
      expect_v("stop_run", 12'h000);
      press(1'b0, 1'b1, 1'b0);
      check_v(12'(running));
      for (int i = 0; i < 20; i++) begin
         expect_v("pause_bcd", 12'h002);
         step();
         check_v(bcd);
      end
      expect_v("resume_run", 12'h001);
      expect_v("resume_e0", 12'h002);
      press(1'b1, 1'b0, 1'b0);
      check_v(12'(running));
      check_v(bcd);
      expect_v("resume_e1", 12'h002);
      step();
      check_v(bcd);
      expect_v("resume_e2", 12'h003);
      step();
      check_v(bcd);

      // full run through 999 -> 000 and on to 123
      expect_v("clear_bcd", 12'h000);
      expect_v("clear_run", 12'h000);
      press(1'b0, 1'b0, 1'b1);
      check_v(bcd);
      check_v(12'(running));
      press(1'b1, 1'b0, 1'b0);
      for (int n = 1; n <= 4492; n++) begin
         if (n % 4 == 0) expect_v("count", to_bcd((n / 4) % 1000));
         expect_v("wrap", (n == 4000) ? 12'h001 : 12'h000);
         if (n == 4000) expect_v("wrap_run", 12'h001);
         step();
         if (n % 4 == 0) check_v(bcd);
         check_v(12'(wrap));
         if (n == 4000) check_v(12'(running));
      end

      // start+stop+clear together while running at 123
      expect_v("all3_bcd", 12'h000);
      expect_v("all3_run", 12'h000);
      press(1'b1, 1'b1, 1'b1);
      check_v(bcd);
      check_v(12'(running));
      repeat (8) step();
      expect_v("idle_hold", 12'h000);
      check_v(bcd);

      // start+stop while paused keeps it paused
      press(1'b1, 1'b0, 1'b0);
      repeat (8) step();
      expect_v("pre_pause", 12'h002);
      check_v(bcd);
      press(1'b0, 1'b1, 1'b0);
      expect_v("ss_pause_run", 12'h000);
      press(1'b1, 1'b1, 1'b0);
      check_v(12'(running));
      repeat (8) step();
      expect_v("ss_pause_bcd", 12'h002);
      expect_v("ss_pause_run2", 12'h000);
      check_v(bcd);
      check_v(12'(running));

      // display of 007 across all three digit slots
      press(1'b0, 1'b0, 1'b1);
      press(1'b1, 1'b0, 1'b0);
      repeat (28) step();
      expect_v("cnt007", 12'h007);
      check_v(bcd);
      press(1'b0, 1'b1, 1'b0);
      seen = 3'b000;
      for (int i = 0; i < 8; i++) begin
         step();
         case (dig_sel)
            3'b001: expect_v("slot_ones", 12'h0E0);
            3'b010: expect_v("slot_tens", 12'(LEAD_ZERO));
            3'b100: expect_v("slot_hunds", 12'(LEAD_ZERO));
            default: expect_v("slot_onehot", 12'hFFF);
         endcase
         seen = seen | dig_sel;
         check_v(12'(seg_out));
      end
      expect_v("slots_seen", 12'h007);
      check_v(12'(seen));

      // asynchronous reset mid-run, between clock edges
      press(1'b1, 1'b0, 1'b0);
      repeat (5) step();
      #2;
      rst = 1'b0;
      #1;
      expect_v("arst_seg", 12'h0FC);   check_v(12'(seg_out));
      expect_v("arst_dig", 12'h001);   check_v(12'(dig_sel));
      expect_v("arst_bcd", 12'h000);   check_v(bcd);
      expect_v("arst_run", 12'h000);   check_v(12'(running));
      expect_v("arst_wrap", 12'h000);  check_v(12'(wrap));
      #10;
      rst = 1'b1;
      step();

      if (sb.size() != 0) begin
         fails++;
         $error("FAIL scoreboard_left: got %0d entries expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/stopwatch_seg_ctrl.md
# stopwatch_seg_ctrl

Run/pause/clear controller for the three-digit 000–999 decimal display counter, plus a time-multiplexed scanner that shares one 8-bit segment bus among the three digits.
- Sequences the BCD count from single-cycle button pulses.
- Paces increments with a prescaler.
- Rotates a one-hot digit select so the board needs only one segment driver.
- Sits between the debounced button synchronizers and the display pins.

## Interface
- `TICK_DIV`, 1000: clk cycles per count increment while running (≥2).
- `SCAN_DIV`, 50: clk cycles each digit is held on the shared bus (≥1).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `btn_start`  in  1  single-cycle pulse, already synchronized to clk.
- `btn_stop`  in  1  single-cycle pulse, already synchronized to clk.
- `btn_clear`  in  1  single-cycle pulse, already synchronized to clk.
- `seg_out`  out  8  segment pattern for the selected digit. Bit 7 = a … bit 1 = g, bit 0 = dp; active-high.
- `dig_sel`  out  3  one-hot digit select: [0] ones, [1] tens, [2] hundreds.
- `bcd`  out  12  current count as {hundreds, tens, ones}, 4-bit BCD each.
- `running`  out  1  high while in RUN.
- `wrap`  out  1  one-cycle pulse on the 999→000 rollover.

## Operation
- FSM states:
  - IDLE: count 000, prescaler 0.
  - RUN: prescaler advances.
  - PAUSE: count and prescaler frozen.
- Button priority: clear > stop > start.
- Transitions:
  - clear in any state → IDLE. Count and prescaler are zeroed on the same edge.
  - RUN + stop → PAUSE.
  - IDLE or PAUSE + start → RUN.
  - start together with stop: in RUN, stop wins; in IDLE or PAUSE, no transition.
  - start in RUN, or stop in IDLE or PAUSE: ignored.
- Prescaler `tick_cnt` counts 0..TICK_DIV-1, and only in RUN.
  - At TICK_DIV-1 it returns to 0 and the count increments.
  - PAUSE holds the prescaler phase, so resume continues the partial interval.
- Count increment is BCD ripple.
  - A digit at 9 becomes 0 and carries into the next digit.
  - 999 → 000 asserts `wrap` for exactly that one cycle; the state stays RUN.
  - BCD digits never hold values 10–15.
- Scanner runs free in every state, including IDLE and PAUSE.
  - `scan_cnt` counts 0..SCAN_DIV-1; on wrap the digit index rotates ones → tens → hundreds → ones.
  - `seg_out` holds the encoded digit for the new index.
- Segment codes:
  - 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=E6 (hex).
  - Blank = 00.

## Timing
- Reset values: `seg_out`=8'hFC, `dig_sel`=3'b001, `bcd`=12'h000, `running`=0, `wrap`=0, state IDLE, `tick_cnt`=0, `scan_cnt`=0.
- Reset is asynchronous. Asserting it mid-run forces all reset values immediately, regardless of clk.
- `running` is registered with the state and goes high on the same edge that samples `btn_start`.
- With start sampled at edge 0, `bcd` first becomes 001 at edge TICK_DIV. Later increments follow every TICK_DIV edges.
- Paused for P cycles: the next increment occurs P cycles later than it would have without the pause.
- `dig_sel` and `seg_out` are both registered and change on the same edge, so there is never a mismatched digit/pattern cycle.
  - Each digit is held exactly SCAN_DIV cycles.
  - With SCAN_DIV=1 the index rotates every cycle.
- The scanner samples `bcd` as registered. A count change appears on the bus at the next scan edge that selects the changed digit, or immediately if already selected: `seg_out` is updated every cycle from the current index.
- `wrap` is registered and high in the cycle after the edge that produced 000.

## Configuration
- `SEG_LEADING_BLANK_EN` defined: leading-zero blanking.
  - Hundreds shows 00 when hundreds==0.
  - Tens shows 00 when hundreds==0 and tens==0.
  - Ones is never blanked.
  - The reset `seg_out` stays FC because ones is selected.
  - `dig_sel` still rotates through all three digits.
- Not defined: all three digits always display their numeral.
- `bcd` is unaffected either way.

## Structure
- Package `seg_pkg`:
  - segment code constants SEG_0..SEG_9 and SEG_BLANK;
  - FSM state typedef (IDLE, RUN, PAUSE);
  - digit index typedef (2-bit).
- Sub-module `seg_encode`: combinational 4-bit BCD → 8-bit pattern; any value 10–15 → 00.
  - Instantiated once on the muxed digit.

## Test plan
- Reset, hold 10 cycles with TICK_DIV=4, SCAN_DIV=2 → `bcd`=000, `running`=0, `dig_sel` sequence 001,001,010,010,100,100,…, `seg_out`=FC throughout.
- Start at edge 0 → `bcd`=001 at edge 4, 002 at edge 8; `running`=1 from edge 0.
- Stop 2 cycles after an increment, wait 20 cycles, start → next increment 2 cycles after the start edge; `bcd` unchanged during pause.
- Preload by running to 998, then run → 999, then 000 with `wrap` high one cycle; tens and hundreds carry; `running` stays 1.
- Start, stop and clear in one cycle while in RUN at 123 → IDLE, `bcd`=000, `running`=0. Separately, start+stop in PAUSE → stays PAUSE.
- With `SEG_LEADING_BLANK_EN` at count 007 → hundreds slot 00, tens slot 00, ones slot E0. Without the macro → FC, FC, E0.
